// File: rtl/mac_pkg.sv
// Shared widths, types and helpers for the MAC result collector slice.
package mac_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = 8;

  typedef logic [DATA_W-1:0] result_t;
  typedef logic [CNT_W-1:0]  occ_t;

  // Saturating increment for the dropped-result counter.
  function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/mac_result_ram.sv
// Result storage: one synchronous write port, one asynchronous read port.
module mac_result_ram #(
  parameter int unsigned DATA_W = mac_pkg::DATA_W,
  parameter int unsigned DEPTH  = mac_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; validity is tracked by the collector pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mac_result_collector.sv
// Buffers a*b+c results from a non-stalling upstream, counting drops and summing accepts.
module mac_result_collector #(
  parameter int unsigned DATA_W = mac_pkg::DATA_W,
  parameter int unsigned DEPTH  = mac_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     validi,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     readyi,
  output logic                     valido,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic [DATA_W-1:0]        acc_sum
);

  import mac_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DATA_W-1:0] head_data;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  logic              wr_en_c;

  // Status and handshake decode from registered occupancy; valido never sees readyi.
  always_comb begin
    empty    = (count == '0);
    full     = (count == CNT_W'(DEPTH));
    valido   = !empty;
    pop_c    = valido && readyi;
    push_c   = validi && (!full || pop_c);
    drop_c   = validi && full && !pop_c;
    wr_en_c  = push_c && !rst;
    data_out = valido ? head_data : '0;
  end

  mac_result_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (tail),
    .wdata (data_in),
    .raddr (head),
    .rdata (head_data)
  );

  // Pointers, occupancy and statistics; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      acc_sum  <= '0;
    end else begin
      if (push_c) begin
        tail    <= tail + PTR_W'(1);
        acc_sum <= acc_sum + data_in;
      end
      if (pop_c) begin
        head <= head + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop_c) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc_drop(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_mac_result_collector.sv
// Randomized and directed scoreboard bench for mac_result_collector.
module tb_mac_result_collector;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              validi;
  logic [DATA_W-1:0] data_in;
  logic              readyi;
  logic              valido;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic [2:0]        count;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic [DATA_W-1:0] acc_sum;

  int total = 0;
  int bad   = 0;

  // Reference model state: occupancy, running sum, drops, and expected output order.
  int                mcount = 0;
  logic [DATA_W-1:0] msum   = '0;
  int                mdrop  = 0;
  bit                mov    = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  mac_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .validi   (validi),
    .data_in  (data_in),
    .readyi   (readyi),
    .valido   (valido),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .acc_sum  (acc_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    chk("count", 64'(count), 64'(mcount));
    chk("empty", 64'(empty), 64'(mcount == 0));
    chk("full", 64'(full), 64'(mcount == DEPTH));
    chk("valido", 64'(valido), 64'(mcount != 0));
    chk("overflow", 64'(overflow), 64'(mov));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    chk("acc_sum", 64'(acc_sum), 64'(msum));
    if (mcount == 0) chk("data_out_when_empty", 64'(data_out), 64'd0);
  endtask

  // Drive one cycle of inputs, advance the model, then check the post-edge state.
  task automatic step(input bit r, input bit v, input logic [DATA_W-1:0] d, input bit rdy);
    bit pop_m;
    rst = r; validi = v; data_in = d; readyi = rdy;
    if (r) begin
      mcount = 0; msum = '0; mdrop = 0; mov = 1'b0;
      exp_q.delete();
    end else begin
      pop_m = (mcount > 0) && rdy;
      if (v) begin
        if (mcount < DEPTH || pop_m) begin
          exp_q.push_back(d);
          msum = msum + d;
          mcount++;
        end else begin
          mov = 1'b1;
          if (mdrop < 255) mdrop++;
        end
      end
      if (pop_m) mcount--;
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  // Monitor: each accepted output must match the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && valido === 1'b1 && readyi === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL head_unexpected: got %0h expected nothing at %0t", data_out, $time);
      end else begin
        chk("head_order", 64'(data_out), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset held two cycles with a pending result that must not land.
    step(1'b1, 1'b1, 32'd7, 1'b0);
    step(1'b1, 1'b1, 32'd7, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_data_out", 64'(data_out), 64'd0);
    chk("reset_acc_sum", 64'(acc_sum), 64'd0);

    // Single result, then consume it.
    step(1'b0, 1'b1, 32'd23, 1'b0);
    chk("single_data", 64'(data_out), 64'd23);
    chk("single_valido", 64'(valido), 64'd1);
    chk("single_acc", 64'(acc_sum), 64'd23);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("single_empty", 64'(empty), 64'd1);

    // Fill and overflow from a clean start.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, DATA_W'(i), 1'b0);
      if (i == 4) chk("fill_full", 64'(full), 64'd1);
    end
    chk("fill_overflow", 64'(overflow), 64'd1);
    chk("fill_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("fill_acc", 64'(acc_sum), 64'd10);

    // Full buffer with simultaneous push and pop.
    step(1'b0, 1'b1, 32'd9, 1'b1);
    chk("fullpp_count", 64'(count), 64'd4);
    chk("fullpp_head", 64'(data_out), 64'd2);
    chk("fullpp_acc", 64'(acc_sum), 64'd19);
    chk("fullpp_drop", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Drop counter saturation while stalled full.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DATA_W'(100 + i), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, DATA_W'(i), 1'b0);
    chk("sat_drop_cnt", 64'(drop_cnt), 64'd255);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Accumulator wrap.
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 1'b1, 32'd2, 1'b1);
    chk("acc_wrap", 64'(acc_sum), 64'd1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Reset mid-stream with three entries and a recorded drop.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DATA_W'(40 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("mid_count3", 64'(count), 64'd3);
    step(1'b1, 1'b1, 32'd55, 1'b1);
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_overflow", 64'(overflow), 64'd0);
    chk("mid_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("mid_valido", 64'(valido), 64'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      else
        step(1'b0, ($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
